// File: rtl/dsm_pkg.sv
// Shared types and code constants for the delta-sigma bridge driver slice.
package dsm_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DEAD = 2'd3
    } leg_state_t;

    localparam logic [1:0] PWM_ZERO    = 2'b00;
    localparam logic [1:0] PWM_POS     = 2'b01;
    localparam logic [1:0] PWM_NEG     = 2'b11;
    localparam logic [1:0] PWM_ILLEGAL = 2'b10;

endpackage

// File: rtl/bridge_leg.sv
// One half-bridge leg: OFF/LO/HI/DEAD FSM with a dead-time counter that is
// loaded on DEAD entry and never restarted by target changes while dead.
module bridge_leg
    import dsm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic target_hi,
    input  logic force_off,
    output logic gate_h,
    output logic gate_l
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    leg_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (force_off) begin
            state_d = OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                end
                LO: begin
                    if (target_hi) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                HI: begin
                    if (!target_hi) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end
                DEAD: begin
                    // Expiry picks up whatever the target is now.
                    if (cnt_q == '0) begin
                        state_d = target_hi ? HI : LO;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        gate_h = (state_q == HI);
        gate_l = (state_q == LO);
    end

endmodule

// File: rtl/dsm_bridge_driver.sv
// H-bridge gate driver: decodes ternary PWM codes into two dead-timed legs,
// latches faults and counts illegal codes.
module dsm_bridge_driver
    import dsm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       pwm_i,
    input  logic             en_i,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    output logic             gate_ah_o,
    output logic             gate_al_o,
    output logic             gate_bh_o,
    output logic             gate_bl_o,
    output logic             fault_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    logic             fault_q, fault_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_hi, b_hi, force_off;

    always_comb begin
        a_hi = (pwm_i == PWM_POS);
        b_hi = (pwm_i == PWM_NEG);
        // A raw fault_i also forces off so gates drop on the same edge the latch sets.
        force_off = ~en_i | fault_i | fault_q;
    end

    always_comb begin
        fault_d = fault_q;
        if (fault_i) begin
            fault_d = 1'b1;
        end else if (fault_clr_i) begin
            fault_d = 1'b0;
        end
        illegal_d = (pwm_i == PWM_ILLEGAL);
        cnt_d     = cnt_q;
        if (illegal_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_leg_a (
        .clock    (clock),
        .reset    (reset),
        .target_hi(a_hi),
        .force_off(force_off),
        .gate_h   (gate_ah_o),
        .gate_l   (gate_al_o)
    );

    bridge_leg #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_leg_b (
        .clock    (clock),
        .reset    (reset),
        .target_hi(b_hi),
        .force_off(force_off),
        .gate_h   (gate_bh_o),
        .gate_l   (gate_bl_o)
    );

    assign fault_o       = fault_q;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Directed bench for dsm_bridge_driver with a timestamp-based leg model and
// per-cycle output comparison.
module tb_dsm_bridge_driver;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] pwm_i;
    logic       en_i, fault_i, fault_clr_i;
    logic       gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o;
    logic       fault_o, illegal_o;
    logic [7:0] illegal_cnt_o;

    int total = 0;
    int bad   = 0;

    dsm_bridge_driver #(
        .DEAD_CYCLES(D),
        .CNT_W      (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_i        (pwm_i),
        .en_i         (en_i),
        .fault_i      (fault_i),
        .fault_clr_i  (fault_clr_i),
        .gate_ah_o    (gate_ah_o),
        .gate_al_o    (gate_al_o),
        .gate_bh_o    (gate_bh_o),
        .gate_bl_o    (gate_bl_o),
        .fault_o      (fault_o),
        .illegal_o    (illegal_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: drive 0=none 1=low 2=high; a leg that starts blanking at edge n
    // drives whatever its target is at edge n+D.
    int edge_n   = 0;
    int drv[2]   = '{0, 0};
    int dend[2]  = '{-1, -1};
    bit moff[2]  = '{1'b1, 1'b1};
    bit m_fault  = 1'b0;
    bit m_ill    = 1'b0;
    int m_cnt    = 0;
    bit started  = 1'b0;

    always @(posedge clock) begin
        bit forced;
        int tgt;
        edge_n++;
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                drv[l] = 0; dend[l] = -1; moff[l] = 1'b1;
            end
            m_fault = 1'b0; m_ill = 1'b0; m_cnt = 0;
        end else begin
            forced = !en_i || fault_i || m_fault;
            for (int l = 0; l < 2; l++) begin
                if (l == 0) tgt = (pwm_i == 2'b01) ? 2 : 1;
                else        tgt = (pwm_i == 2'b11) ? 2 : 1;
                if (forced) begin
                    drv[l] = 0; dend[l] = -1; moff[l] = 1'b1;
                end else if (moff[l]) begin
                    moff[l] = 1'b0; drv[l] = 0; dend[l] = edge_n + D;
                end else if (dend[l] >= 0) begin
                    if (edge_n == dend[l]) begin
                        drv[l] = tgt; dend[l] = -1;
                    end
                end else if (drv[l] != tgt) begin
                    drv[l] = 0; dend[l] = edge_n + D;
                end
            end
            if (fault_i) m_fault = 1'b1;
            else if (fault_clr_i) m_fault = 1'b0;
            m_ill = (pwm_i == 2'b10);
            if (m_ill && m_cnt < 255) m_cnt++;
        end
        started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("gate_ah", int'(gate_ah_o), int'(drv[0] == 2));
            chk("gate_al", int'(gate_al_o), int'(drv[0] == 1));
            chk("gate_bh", int'(gate_bh_o), int'(drv[1] == 2));
            chk("gate_bl", int'(gate_bl_o), int'(drv[1] == 1));
            chk("fault_o", int'(fault_o), int'(m_fault));
            chk("illegal_o", int'(illegal_o), int'(m_ill));
            chk("illegal_cnt", int'(illegal_cnt_o), m_cnt);
            chk("shoot_a", int'(gate_ah_o & gate_al_o), 0);
            chk("shoot_b", int'(gate_bh_o & gate_bl_o), 0);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    function automatic int gates();
        return {28'd0, gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o};
    endfunction

    initial begin
        reset = 1'b1; pwm_i = 2'b01; en_i = 1'b1; fault_i = 1'b0; fault_clr_i = 1'b0;
        tick(3);
        chk("rst_gates", gates(), 0);
        chk("rst_fault", int'(fault_o), 0);
        chk("rst_cnt", int'(illegal_cnt_o), 0);

        reset = 1'b0; en_i = 1'b0; pwm_i = 2'b00;
        tick(3);
        chk("dis_gates", gates(), 0);

        // enable with 00: dark for D edges, then both low sides
        en_i = 1'b1;
        for (int i = 1; i <= D; i++) begin
            tick(1);
            chk("en_dead", gates(), 0);
        end
        tick(1);
        chk("en_lo", gates(), 4'b0101);

        // 00 -> 01
        pwm_i = 2'b01;
        tick(1);
        chk("pos_off", gates(), 4'b0001);
        tick(D - 1);
        chk("pos_pre", gates(), 4'b0001);
        tick(1);
        chk("pos_on", gates(), 4'b1001);

        // 01 -> 11: both legs dead together
        pwm_i = 2'b11;
        for (int i = 1; i <= D; i++) begin
            tick(1);
            chk("neg_dead", gates(), 0);
        end
        tick(1);
        chk("neg_on", gates(), 4'b0110);

        pwm_i = 2'b00;
        tick(D + 2);
        chk("zero_lo", gates(), 4'b0101);

        // short 01 glitch produces no high-side pulse on leg A
        pwm_i = 2'b01;
        tick(1);
        chk("gl_al", int'(gate_al_o), 0);
        tick(1);
        pwm_i = 2'b00;
        for (int i = 3; i <= D; i++) begin
            tick(1);
            chk("gl_dead", gates(), 4'b0001);
        end
        tick(1);
        chk("gl_back", gates(), 4'b0101);

        // fault while running high
        pwm_i = 2'b01;
        tick(D + 1);
        chk("hi_run", gates(), 4'b1001);
        fault_i = 1'b1;
        tick(1);
        chk("flt_gates", gates(), 0);
        chk("flt_o", int'(fault_o), 1);
        fault_i = 1'b0;
        tick(2);
        chk("flt_hold", int'(fault_o), 1);
        fault_i = 1'b1; fault_clr_i = 1'b1;
        tick(1);
        chk("flt_wins", int'(fault_o), 1);
        fault_i = 1'b0;
        tick(1);
        chk("flt_clr", int'(fault_o), 0);
        fault_clr_i = 1'b0;
        for (int i = 1; i <= D; i++) begin
            tick(1);
            chk("rec_dead", gates(), 0);
        end
        tick(1);
        chk("rec_on", gates(), 4'b1001);

        // disable for one cycle
        en_i = 1'b0;
        tick(1);
        chk("dis_off", gates(), 0);
        en_i = 1'b1;
        tick(D + 1);
        chk("dis_rec", gates(), 4'b1001);

        // long run of illegal codes
        pwm_i = 2'b10;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            chk("ill_pulse", int'(illegal_o), 1);
        end
        chk("ill_sat", int'(illegal_cnt_o), 255);
        chk("ill_gates", gates(), 4'b0101);
        pwm_i = 2'b00;
        tick(1);
        chk("ill_end", int'(illegal_o), 0);
        chk("ill_keep", int'(illegal_cnt_o), 255);

        reset = 1'b1;
        tick(1);
        chk("rst2_cnt", int'(illegal_cnt_o), 0);
        chk("rst2_gates", gates(), 0);
        reset = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
